// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master side is the fetch unit; the slave side is the memory and decode environment.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] pc_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output instr_valid_o, instr_o, pc_o, rs1_o, rs2_o, rd_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  instr_valid_o, instr_o, pc_o, rs1_o, rs2_o, rd_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request/grant fetch, in-order
// instruction buffer, and redirect with squashing of in-flight responses.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_unit_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [PW-1:0]   ptr_t;
  typedef logic [CW-1:0]   cnt_t;
  typedef logic [XLEN-1:0] addr_t;

  addr_t fetch_pc_q, fetch_pc_d;
  addr_t resp_pc_q,  resp_pc_d;
  ptr_t  wr_ptr_q,   wr_ptr_d;
  ptr_t  rd_ptr_q,   rd_ptr_d;
  cnt_t  count_q,    count_d;
  cnt_t  outst_q,    outst_d;
  cnt_t  kill_q,     kill_d;

  logic [31:0] instr_mem_q [FIFO_DEPTH];
  addr_t       pc_mem_q    [FIFO_DEPTH];

  logic credit_ok, req, xfer, rsp, drop, wr_en, pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    kill_d     = kill_q;

    // In-flight plus buffered instructions never exceed the buffer size.
    credit_ok = ({1'b0, outst_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
    req       = rst_i & ~bus.redirect_i & credit_ok;
    xfer      = req & bus.imem_gnt_i;
    rsp       = bus.imem_rvalid_i & (outst_q != '0);
    drop      = rsp & (kill_q != '0);
    wr_en     = rsp & ~drop & ~bus.redirect_i;
    pop       = (count_q != '0) & bus.instr_ready_i;

    outst_d = outst_q + cnt_t'(xfer) - cnt_t'(rsp);
    if (xfer) fetch_pc_d = fetch_pc_q + addr_t'(4);

    if (bus.redirect_i) begin
      // Everything still in flight belongs to the old stream, except a response landing now.
      fetch_pc_d = bus.redirect_pc_i;
      resp_pc_d  = bus.redirect_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      kill_d     = outst_q - cnt_t'(rsp);
    end else begin
      if (drop) kill_d = kill_q - cnt_t'(1);
      if (wr_en) begin
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
        resp_pc_d = resp_pc_q + addr_t'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(wr_en) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      kill_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = rst_i & (count_q != '0);
  assign bus.instr_o       = instr_mem_q[rd_ptr_q];
  assign bus.pc_o          = pc_mem_q[rd_ptr_q];
  assign bus.rs1_o         = bus.instr_o[19:15];
  assign bus.rs2_o         = bus.instr_o[24:20];
  assign bus.rd_o          = bus.instr_o[11:7];

  // A response with nothing outstanding is a memory protocol violation.
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_i)
    bus.imem_rvalid_i |-> (outst_q != '0));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation core. It replaces the single-cycle PC register and combinational instruction-ROM path with the following:
- a request/grant/response instruction-memory interface with variable latency;
- an in-order instruction buffer of configurable depth;
- redirect (branch/jump) support with squashing of in-flight responses;
- a valid/ready handshake to the decode stage, which also receives register-index fields pre-split.

Parameters:
XLEN, 32, width of PC, addresses and instruction words.
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also the cap on in-flight plus buffered instructions.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  reset, synchronous, active-low.
imem_req_o  out  1  fetch request valid.
imem_addr_o  out  XLEN  fetch address (current fetch PC).
imem_gnt_i  in  1  memory accepts request this cycle (transfer = req & gnt).
imem_rvalid_i  in  1  response valid; responses return in request order, at earliest the cycle after grant.
imem_rdata_i  in  32  instruction word for oldest outstanding request.
redirect_i  in  1  redirect fetch stream (taken branch/jump).
redirect_pc_i  in  XLEN  new fetch PC.
instr_valid_o  out  1  buffer head valid.
instr_ready_i  in  1  decode accepts head (pop = valid & ready).
instr_o  out  32  head instruction word.
pc_o  out  XLEN  PC of head instruction.
rs1_o  out  5  instr_o[19:15].
rs2_o  out  5  instr_o[24:20].
rd_o  out  5  instr_o[11:7].

Behaviour:
State: fetch_pc, buffer (instr+pc per entry, rd/wr pointers, count 0..FIFO_DEPTH), outstanding counter (0..FIFO_DEPTH), kill counter (0..FIFO_DEPTH).

Reset (rst_i=0 at edge):
- fetch_pc=RESET_PC; buffer empty; outstanding=0; kill=0.
- instr_valid_o=0 and imem_req_o=0 while rst_i=0.
- A mid-operation reset drops everything; responses still arriving after reset release are ignored only while outstanding=0 (memory must be idle-reset alongside).

Request issue:
- imem_req_o = rst_i & ~redirect_i & (outstanding + count < FIFO_DEPTH).
- On transfer: fetch_pc += 4 (mod 2^XLEN, wraps silently) and outstanding++.
- imem_addr_o = fetch_pc. Request and address hold until granted.

Response:
- On imem_rvalid_i, outstanding-- (net with a simultaneous transfer).
- If kill>0: data discarded and kill--. Otherwise: entry {imem_rdata_i, pc} is written to the buffer.
- The pc for each entry comes from a response-PC register: set to fetch address order, i.e. it starts at RESET_PC/redirect_pc_i and does +4 per non-killed write.
- The credit rule guarantees the buffer never overflows. A response with outstanding=0 is a protocol error (assertion); the data is ignored.

Output:
- instr_valid_o = (count>0). Outputs are the head entry, registered storage with no bypass.
- Minimum latency: grant in cycle t, rvalid in t+1, instr_valid_o in t+2.
- Pop advances head; a simultaneous write and pop keeps count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Output fields are stable while valid & ~ready.

Redirect (redirect_i=1):
- Buffer flushed (count=0) at the edge; a pop the same cycle is ignored.
- fetch_pc=redirect_pc_i; response-PC register=redirect_pc_i.
- kill = outstanding - imem_rvalid_i, i.e. any response in the redirect cycle is also dropped.
- No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins; kill is recomputed each time.
- Requests for the new stream may issue while kill>0; the oldest responses are consumed by kill first.

Test Plan:
- Reset release, mem grants every cycle with 1-cycle latency, words 0x00000013+k -> imem_addr 0,4,8,...; instr_valid_o first high 2 cycles after first grant; pc_o 0,4,8 with matching instr; rs1/rs2/rd match field slices.
- instr_ready_i held 0 -> exactly FIFO_DEPTH (4) requests issued, then imem_req_o stays 0; imem_addr_o frozen at 0x10; head stays pc 0; releasing ready resumes issue with no loss or duplication.
- 3 requests outstanding (latency 3), redirect_i with redirect_pc_i=0x100 -> buffer empty next cycle, 3 stale responses dropped; first delivered instr has pc_o=0x100, followed by 0x104.
- Redirect in the same cycle as rvalid and valid&ready -> the returning word is dropped, the pop is ignored, kill equals outstanding-1, and no request is issued that cycle.
- imem_gnt_i toggled randomly, latency 1-4 cycles -> instruction/PC stream in strict order; outstanding+count never exceeds 4.
- rst_i driven low mid-stream with buffer full -> next cycle instr_valid_o=0, imem_req_o=0; after release the first request is at RESET_PC.
